// File: rtl/reg_file_pc_pkg.sv
// Shared constants and index helpers for the ARM-style register file with an internal PC.
// The PC and LR sit at the top two indices of the register array.
package reg_file_pc_pkg;

   localparam int DEF_W         = 32;
   localparam int DEF_PC_OFFSET = 8;
   localparam int PC_STEP       = 4;

   function automatic int pc_index(input int a);
      return (1 << a) - 1;
   endfunction

   function automatic int lr_index(input int a);
      return (1 << a) - 2;
   endfunction

endpackage

// File: rtl/reg_file_pc_cell.sv
// W-bit storage cell with load enable and asynchronous active-low clear.
// Used for every general register and for the link register.
module reg_cell_ar #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/reg_file_pc.sv
// Register file with two combinational read ports, one write port and an internal,
// self-incrementing PC with a single-cycle branch-and-link path.
module reg_file_pc
   import reg_file_pc_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int A         = 4,
   parameter int PC_OFFSET = DEF_PC_OFFSET,
   parameter int BYPASS    = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         write_enable,
   input  logic [A-1:0] adr_dst,
   input  logic [W-1:0] DATA_in,
   input  logic [A-1:0] adr_src1,
   input  logic [A-1:0] adr_src2,
   output logic [W-1:0] DATA_out_1,
   output logic [W-1:0] DATA_out_2,
   input  logic         pc_inc,
   input  logic         pc_load,
   input  logic [W-1:0] pc_target,
   input  logic         link,
   output logic [W-1:0] pc_out
);

   localparam int           N      = 1 << A;
   localparam int           P      = pc_index(A);
   localparam int           L      = lr_index(A);
   localparam logic [A-1:0] P_ADR  = A'(P);
   localparam logic [A-1:0] L_ADR  = A'(L);
   localparam logic [W-1:0] STEP_W = W'(PC_STEP);
   localparam logic [W-1:0] OFF_W  = W'(PC_OFFSET);

   logic [W-1:0] pc_q;
   logic [W-1:0] pc_d;
   logic [W-1:0] pc_plus_step;
   logic         link_wr;

   // Per-address view used by both read ports; slot P is the offset PC and never written.
   logic [N-1:0] wr_en;
   logic [W-1:0] wr_dat [N];
   logic [W-1:0] rd_val [N];

   assign pc_plus_step = pc_q + STEP_W;
   assign link_wr      = pc_load & link;

   for (genvar i = 0; i < N - 1; i++) begin : g_cell
      if (i == L) begin : g_lr
         // A linked branch owns LR this cycle; a general write to LR is dropped.
         assign wr_en[i]  = link_wr | (write_enable && (adr_dst == L_ADR));
         assign wr_dat[i] = link_wr ? pc_plus_step : DATA_in;
      end else begin : g_gp
         assign wr_en[i]  = write_enable && (adr_dst == A'(i));
         assign wr_dat[i] = DATA_in;
      end

      reg_cell_ar #(
         .W(W)
      ) u_cell (
         .clk_i (clk),
         .rst_ni(reset),
         .en_i  (wr_en[i]),
         .d_i   (wr_dat[i]),
         .q_o   (rd_val[i])
      );
   end

   assign wr_en[P]  = 1'b0;
   assign wr_dat[P] = '0;
   assign rd_val[P] = pc_q + OFF_W;

   always_comb begin
      pc_d = pc_q;
      if (write_enable && (adr_dst == P_ADR)) begin
         pc_d = DATA_in;
      end else if (pc_load) begin
         pc_d = pc_target;
      end else if (pc_inc) begin
         pc_d = pc_plus_step;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Forwarding is suppressed while reset is held, since that write will be discarded.
   assign DATA_out_1 = ((BYPASS != 0) && reset && wr_en[adr_src1]) ? wr_dat[adr_src1]
                                                                   : rd_val[adr_src1];
   assign DATA_out_2 = ((BYPASS != 0) && reset && wr_en[adr_src2]) ? wr_dat[adr_src2]
                                                                   : rd_val[adr_src2];
   assign pc_out     = pc_q;

endmodule

// File: tb/tb_reg_file_pc.sv
// Bench for reg_file_pc: directed scenarios plus random traffic against a behavioural model,
// with one instance built without forwarding and one with forwarding.
module tb_reg_file_pc;

   localparam int W = 32;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         write_enable;
   logic [A-1:0] adr_dst;
   logic [W-1:0] DATA_in;
   logic [A-1:0] adr_src1;
   logic [A-1:0] adr_src2;
   logic         pc_inc;
   logic         pc_load;
   logic [W-1:0] pc_target;
   logic         link;

   logic [W-1:0] d1_nb, d2_nb, pc_nb;
   logic [W-1:0] d1_bp, d2_bp, pc_bp;

   int n_chk  = 0;
   int n_pass = 0;

   logic [W-1:0] m_reg [16];
   logic [W-1:0] m_pc;

   always #5 clk = ~clk;

   reg_file_pc #(.W(W), .A(A), .PC_OFFSET(8), .BYPASS(0)) u_nb (
      .clk(clk), .reset(reset), .write_enable(write_enable), .adr_dst(adr_dst),
      .DATA_in(DATA_in), .adr_src1(adr_src1), .adr_src2(adr_src2),
      .DATA_out_1(d1_nb), .DATA_out_2(d2_nb), .pc_inc(pc_inc), .pc_load(pc_load),
      .pc_target(pc_target), .link(link), .pc_out(pc_nb)
   );

   reg_file_pc #(.W(W), .A(A), .PC_OFFSET(8), .BYPASS(1)) u_bp (
      .clk(clk), .reset(reset), .write_enable(write_enable), .adr_dst(adr_dst),
      .DATA_in(DATA_in), .adr_src1(adr_src1), .adr_src2(adr_src2),
      .DATA_out_1(d1_bp), .DATA_out_2(d2_bp), .pc_inc(pc_inc), .pc_load(pc_load),
      .pc_target(pc_target), .link(link), .pc_out(pc_bp)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_pc = '0;
   endfunction

   // Value a read port should show this cycle, with or without forwarding.
   function automatic logic [W-1:0] m_read(input logic [A-1:0] a, input bit bp);
      if (a == 4'd15) return m_pc + 32'd8;
      if (bp) begin
         if (a == 4'd14 && pc_load && link) return m_pc + 32'd4;
         if (write_enable && adr_dst == a) return DATA_in;
      end
      return m_reg[a];
   endfunction

   function automatic void m_step();
      logic [W-1:0] old_pc;
      bit           bl;
      old_pc = m_pc;
      bl     = pc_load && link;
      if (write_enable && adr_dst != 4'd15 && !(adr_dst == 4'd14 && bl))
         m_reg[adr_dst] = DATA_in;
      if (bl) m_reg[14] = old_pc + 32'd4;
      if (write_enable && adr_dst == 4'd15) m_pc = DATA_in;
      else if (pc_load)                    m_pc = pc_target;
      else if (pc_inc)                     m_pc = old_pc + 32'd4;
   endfunction

   task automatic idle();
      write_enable = 0; adr_dst = '0; DATA_in = '0; pc_inc = 0;
      pc_load = 0; pc_target = '0; link = 0;
   endtask

   // Caller is positioned just after a rising edge; returns just after the next one.
   task automatic cyc(input logic we, input logic [A-1:0] ad, input logic [W-1:0] din,
                      input logic [A-1:0] s1, input logic [A-1:0] s2, input logic inc,
                      input logic ld, input logic [W-1:0] tgt, input logic lk);
      write_enable = we; adr_dst = ad; DATA_in = din; adr_src1 = s1; adr_src2 = s2;
      pc_inc = inc; pc_load = ld; pc_target = tgt; link = lk;
      @(negedge clk);
      chk("rd1_nobyp", d1_nb, m_read(s1, 0));
      chk("rd2_nobyp", d2_nb, m_read(s2, 0));
      chk("rd1_byp",   d1_bp, m_read(s1, 1));
      chk("rd2_byp",   d2_bp, m_read(s2, 1));
      chk("pc_nobyp",  pc_nb, m_pc);
      chk("pc_byp",    pc_bp, m_pc);
      @(posedge clk);
      m_step();
      #1;
      idle();
   endtask

   task automatic peek(input string tag, input logic [A-1:0] a, input logic [W-1:0] exp);
      adr_src1 = a;
      #1;
      chk({tag, "_nobyp"}, d1_nb, exp);
      chk({tag, "_byp"},   d1_bp, exp);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      adr_src1 = 4'd15; adr_src2 = 4'd3;
      #1 reset = 1'b0;
      #2;
      chk("rst_rd1_pc", d1_nb, 32'd8);
      chk("rst_rd2",    d2_nb, 32'd0);
      chk("rst_pc",     pc_nb, 32'd0);
      chk("rst_rd1_pc_byp", d1_bp, 32'd8);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      m_clear();

      // r5 write: forwarded only in the bypass build
      cyc(1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd15, 0, 0, '0, 0);
      peek("r5_after", 4'd5, 32'hDEADBEEF);

      repeat (3) cyc(0, '0, '0, 4'd15, 4'd5, 1, 0, '0, 0);
      chk("pc_after_inc", pc_nb, 32'd12);
      peek("r15_after_inc", 4'd15, 32'd20);

      cyc(1, 4'd15, 32'hFFFF_FFFC, 4'd15, 4'd0, 0, 0, '0, 0);
      cyc(0, '0, '0, 4'd15, 4'd0, 1, 0, '0, 0);
      chk("pc_wrap", pc_nb, 32'd0);

      cyc(1, 4'd15, 32'h100, 4'd14, 4'd15, 0, 0, '0, 0);
      cyc(1, 4'd14, 32'h55, 4'd14, 4'd15, 0, 1, 32'h400, 1);
      chk("bl_pc", pc_bp, 32'h400);
      peek("bl_lr", 4'd14, 32'h104);

      cyc(1, 4'd15, 32'h200, 4'd15, 4'd14, 1, 1, 32'h300, 0);
      chk("prio_pc", pc_nb, 32'h200);

      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom,
             $urandom_range(0, 1));
      end

      // Asynchronous reset between edges with a write pending
      cyc(1, 4'd5, 32'h1234_5678, 4'd5, 4'd15, 0, 0, '0, 0);
      write_enable = 1; adr_dst = 4'd5; DATA_in = 32'hCAFE_F00D;
      adr_src1 = 4'd15; adr_src2 = 4'd5;
      #1 reset = 1'b0;
      #1;
      chk("arst_pc",      pc_nb, 32'd0);
      chk("arst_rd1",     d1_nb, 32'd8);
      chk("arst_rd2",     d2_nb, 32'd0);
      chk("arst_rd2_byp", d2_bp, 32'd0);
      chk("arst_pc_byp",  pc_bp, 32'd0);
      @(posedge clk); #1;
      chk("arst_hold_rd2", d2_nb, 32'd0);
      reset = 1'b1;
      idle();
      m_clear();

      for (int k = 0; k < 50; k++) begin
         cyc($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom,
             $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
